// File: rtl/motor_pwm_multi.sv
// rtl/motor_pwm_multi.sv - N-motor PWM driver with reversal dead time and period-aligned updates
// Optional soft start: define MOTOR_RAMP_EN.
module motor_pwm_multi #(
  parameter int N_MOT       = 2,
  parameter int CNT_W       = 12,
  parameter int PERIOD      = 2273,
  parameter int DUTY_NORMAL = 100,
  parameter int DUTY_FAST   = 200,
  parameter int DEAD_PER    = 2,
  parameter int RAMP_STEP   = 10
) (
  input  logic               i_clkus,
  input  logic               i_rst,
  input  logic [2*N_MOT-1:0] i_speed,
  output logic [2*N_MOT-1:0] o_motor_ctrl,
  output logic [2*N_MOT-1:0] o_motor_en,
  output logic [N_MOT-1:0]   o_motor_dead
);

  localparam int DW  = CNT_W + 1;
  localparam int DCW = (DEAD_PER < 2) ? 1 : $clog2(DEAD_PER + 1);

  // Duties are clamped to 2**CNT_W so oversized values hold the output on instead of wrapping.
  localparam logic [DW-1:0] L_NORMAL = (DUTY_NORMAL >= 2**CNT_W) ? DW'(2**CNT_W) : DW'(DUTY_NORMAL);
  localparam logic [DW-1:0] L_FAST   = (DUTY_FAST   >= 2**CNT_W) ? DW'(2**CNT_W) : DW'(DUTY_FAST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(PERIOD - 1));

  always_ff @(posedge i_clkus) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_MOT; g++) begin : g_mot
    state_t          r_state, w_state_nxt;
    logic            r_fwd, w_fwd_nxt;
    logic [DCW-1:0]  r_dead_cnt, w_dead_cnt_nxt;
    logic [DW-1:0]   r_duty, w_duty_nxt;
    logic [1:0]      r_ctrl, r_en;
    logic            r_dead;

    logic [1:0]      w_code;
    logic            w_stop, w_code_fwd;
    logic [DW-1:0]   w_tgt, w_entry_duty, w_run_duty;

    assign w_code     = i_speed[2*g+1:2*g];
    assign w_stop     = (w_code == 2'b00);
    assign w_code_fwd = w_code[0];
    assign w_tgt      = (w_code == 2'b11) ? L_FAST : L_NORMAL;

`ifdef MOTOR_RAMP_EN
    localparam logic [DW-1:0] L_STEP = (RAMP_STEP >= 2**CNT_W) ? DW'(2**CNT_W) : DW'(RAMP_STEP);
    logic [DW:0] w_sum;

    // Ramp saturates at the target; a lower target takes effect at once.
    assign w_sum        = {1'b0, r_duty} + {1'b0, L_STEP};
    assign w_entry_duty = (L_STEP >= w_tgt) ? w_tgt : L_STEP;
    assign w_run_duty   = (w_sum >= {1'b0, w_tgt}) ? w_tgt : w_sum[DW-1:0];
`else
    assign w_entry_duty = w_tgt;
    assign w_run_duty   = w_tgt;
`endif

    always_comb begin
      w_state_nxt    = r_state;
      w_fwd_nxt      = r_fwd;
      w_dead_cnt_nxt = r_dead_cnt;
      w_duty_nxt     = r_duty;
      if (w_wrap) begin
        case (r_state)
          S_IDLE: begin
            if (!w_stop) begin
              w_state_nxt = S_RUN;
              w_fwd_nxt   = w_code_fwd;
              w_duty_nxt  = w_entry_duty;
            end
          end
          S_RUN: begin
            if (w_stop) begin
              w_state_nxt = S_IDLE;
            end else if (w_code_fwd == r_fwd) begin
              w_duty_nxt = w_run_duty;
            end else if (DEAD_PER == 0) begin
              w_fwd_nxt  = w_code_fwd;
              w_duty_nxt = w_run_duty;
            end else begin
              w_state_nxt    = S_DEAD;
              w_dead_cnt_nxt = DCW'(DEAD_PER);
            end
          end
          S_DEAD: begin
            // Direction is taken from the code seen when the dead time expires.
            if (w_stop) begin
              w_state_nxt = S_IDLE;
            end else if (r_dead_cnt <= DCW'(1)) begin
              w_state_nxt    = S_RUN;
              w_fwd_nxt      = w_code_fwd;
              w_dead_cnt_nxt = '0;
              w_duty_nxt     = w_entry_duty;
            end else begin
              w_dead_cnt_nxt = r_dead_cnt - 1'b1;
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end

    always_ff @(posedge i_clkus) begin
      if (i_rst) begin
        r_state    <= S_IDLE;
        r_fwd      <= 1'b0;
        r_dead_cnt <= '0;
        r_duty     <= '0;
        r_ctrl     <= 2'b00;
        r_en       <= 2'b00;
        r_dead     <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_fwd      <= w_fwd_nxt;
        r_dead_cnt <= w_dead_cnt_nxt;
        r_duty     <= w_duty_nxt;
        r_ctrl     <= ((r_state == S_RUN) && ({1'b0, r_cnt} < r_duty)) ?
                      (r_fwd ? 2'b10 : 2'b01) : 2'b00;
        r_en       <= (r_state == S_RUN) ? 2'b11 : 2'b00;
        r_dead     <= (r_state == S_DEAD);
      end
    end

    assign o_motor_ctrl[2*g+1:2*g] = r_ctrl;
    assign o_motor_en[2*g+1:2*g]   = r_en;
    assign o_motor_dead[g]         = r_dead;
  end

endmodule

// File: tb/tb_motor_pwm_multi.sv
// tb/tb_motor_pwm_multi.sv - directed checks of motor_pwm_multi at PERIOD=20 (MOTOR_RAMP_EN aware)
module tb_motor_pwm_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] spd_a, spd_b;
  logic [3:0] ctrl_a, en_a, ctrl_b, en_b;
  logic [1:0] dead_a, dead_b;

  int n_chk  = 0;
  int n_pass = 0;
  int tb_cnt = 0;
  int m_fw[2], m_bk[2], m_en[2], m_dd[2], m_first[2];
  int rf1;
  int exp6[4];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == 19) ? 0 : tb_cnt + 1;
  end

  motor_pwm_multi #(
    .N_MOT(2), .CNT_W(12), .PERIOD(20), .DUTY_NORMAL(5), .DUTY_FAST(8),
    .DEAD_PER(2), .RAMP_STEP(3)
  ) u_dut_a (
    .i_clkus(clk), .i_rst(rst), .i_speed(spd_a),
    .o_motor_ctrl(ctrl_a), .o_motor_en(en_a), .o_motor_dead(dead_a)
  );

  motor_pwm_multi #(
    .N_MOT(2), .CNT_W(5), .PERIOD(20), .DUTY_NORMAL(0), .DUTY_FAST(40),
    .DEAD_PER(2), .RAMP_STEP(3)
  ) u_dut_b (
    .i_clkus(clk), .i_rst(rst), .i_speed(spd_b),
    .o_motor_ctrl(ctrl_b), .o_motor_en(en_b), .o_motor_dead(dead_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic goto_cnt0();
    int n = 0;
    while (tb_cnt != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("sync_cnt0", tb_cnt, 0);
  endtask

  // Samples one full period of outputs (they lag cnt by one cycle).
  task automatic measure(input bit sel_b, input int chg_at, input logic [3:0] chg_spd);
    logic [1:0] c, e;
    logic       d;
    for (int m = 0; m < 2; m++) begin
      m_fw[m] = 0; m_bk[m] = 0; m_en[m] = 0; m_dd[m] = 0; m_first[m] = 0;
    end
    goto_cnt0();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tb_cnt == chg_at) spd_a = chg_spd;
      for (int m = 0; m < 2; m++) begin
        c = sel_b ? ctrl_b[2*m +: 2] : ctrl_a[2*m +: 2];
        e = sel_b ? en_b[2*m +: 2]   : en_a[2*m +: 2];
        d = sel_b ? dead_b[m]        : dead_a[m];
        if (c == 2'b10) m_fw[m]++;
        if (c == 2'b01) m_bk[m]++;
        if (e == 2'b11) m_en[m]++;
        if (d)          m_dd[m]++;
        if (c != 2'b00 && m_first[m] == 0) m_first[m] = i;
      end
    end
  endtask

  initial begin
`ifdef MOTOR_RAMP_EN
    rf1 = 3;
    exp6[0] = 3; exp6[1] = 6; exp6[2] = 8; exp6[3] = 8;
`else
    rf1 = 5;
    exp6[0] = 8; exp6[1] = 8; exp6[2] = 8; exp6[3] = 8;
`endif
    rst   = 1'b1;
    spd_a = 4'b0101;
    spd_b = 4'b0111;

    // 1: reset, then both motors forward
    repeat (3) begin
      @(negedge clk);
      chk("rst_ctrl", int'(ctrl_a), 0);
      chk("rst_en", int'(en_a), 0);
      chk("rst_dead", int'(dead_a), 0);
    end
    rst = 1'b0;
    measure(1'b0, -1, 4'b0000);
    chk("t1_idle_en0", m_en[0], 0);
    chk("t1_idle_fw0", m_fw[0], 0);
    measure(1'b0, -1, 4'b0000);
    chk("t1_fw0", m_fw[0], rf1);
    chk("t1_fw1", m_fw[1], rf1);
    chk("t1_en0", m_en[0], 20);
    chk("t1_en1", m_en[1], 20);
    chk("t1_first0", m_first[0], 1);
    measure(1'b0, -1, 4'b0000);
    chk("t1b_fw0", m_fw[0], 5);
    chk("t1b_fw1", m_fw[1], 5);
    chk("t1b_first1", m_first[1], 1);

    // 2: FOR->FAST mid-period
    measure(1'b0, 7, 4'b0111);
    chk("t2_cur_fw0", m_fw[0], 5);
    chk("t2_cur_dead0", m_dd[0], 0);
    measure(1'b0, -1, 4'b0000);
    chk("t2_next_fw0", m_fw[0], 8);
    chk("t2_next_fw1", m_fw[1], 5);
    chk("t2_next_dead0", m_dd[0], 0);

    // 3: FAST->BACK with two dead periods
    measure(1'b0, 7, 4'b0110);
    chk("t3_cur_fw0", m_fw[0], 8);
    measure(1'b0, -1, 4'b0000);
    chk("t3_d1_dead0", m_dd[0], 20);
    chk("t3_d1_en0", m_en[0], 0);
    chk("t3_d1_ctrl0", m_fw[0] + m_bk[0], 0);
    chk("t3_d1_fw1", m_fw[1], 5);
    chk("t3_d1_en1", m_en[1], 20);
    measure(1'b0, -1, 4'b0000);
    chk("t3_d2_dead0", m_dd[0], 20);
    chk("t3_d2_ctrl0", m_fw[0] + m_bk[0], 0);
    chk("t3_d2_dead1", m_dd[1], 0);
    measure(1'b0, -1, 4'b0000);
    chk("t3_run_bk0", m_bk[0], rf1);
    chk("t3_run_en0", m_en[0], 20);
    chk("t3_run_dead0", m_dd[0], 0);
    chk("t3_run_first0", m_first[0], 1);
    chk("t3_run_fw1", m_fw[1], 5);

    // 4: motor1 reversal then STOP while dead; reset mid-pulse
    measure(1'b0, 7, 4'b1010);
    chk("t4_cur_fw1", m_fw[1], 5);
    chk("t4_cur_bk0", m_bk[0], 5);
    measure(1'b0, 7, 4'b0010);
    chk("t4_dead1", m_dd[1], 20);
    chk("t4_dead_bk0", m_bk[0], 5);
    measure(1'b0, -1, 4'b0000);
    chk("t4_stop_dead1", m_dd[1], 0);
    chk("t4_stop_en1", m_en[1], 0);
    chk("t4_stop_ctrl1", m_fw[1] + m_bk[1], 0);
    chk("t4_stop_bk0", m_bk[0], 5);
    goto_cnt0();
    @(negedge clk);
    @(negedge clk);
    chk("t4_pulse_on", int'(ctrl_a[1:0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_ctrl", int'(ctrl_a), 0);
    chk("t4_rst_en", int'(en_a), 0);

    // 6: FAST from IDLE (ramp when enabled), then FAST->FOR
    spd_a = 4'b0011;
    @(negedge clk);
    rst = 1'b0;
    measure(1'b0, -1, 4'b0000);
    chk("t6_idle_en0", m_en[0], 0);
    measure(1'b0, -1, 4'b0000);
    chk("t6_w0", m_fw[0], exp6[0]);
    chk("t6_en1", m_en[1], 0);
    measure(1'b0, -1, 4'b0000);
    chk("t6_w1", m_fw[0], exp6[1]);
    measure(1'b0, -1, 4'b0000);
    chk("t6_w2", m_fw[0], exp6[2]);
    measure(1'b0, 7, 4'b0001);
    chk("t6_w3", m_fw[0], exp6[3]);
    measure(1'b0, -1, 4'b0000);
    chk("t6_for_w", m_fw[0], 5);

    // 5: oversized duty holds ctrl on; zero duty never pulses
    repeat (6) measure(1'b1, -1, 4'b0000);
    measure(1'b1, -1, 4'b0000);
    chk("t5_fast_fw0", m_fw[0], 20);
    chk("t5_fast_en0", m_en[0], 20);
    chk("t5_zero_ctrl1", m_fw[1] + m_bk[1], 0);
    chk("t5_zero_en1", m_en[1], 20);
    chk("t5_dead", m_dd[0] + m_dd[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
